// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - register map, field positions and TX FSM encoding for the UART register block
package uart_pkg;

    // Register indices on rf_addr
    localparam logic [2:0] CTRL    = 3'd0;
    localparam logic [2:0] STATUS  = 3'd1;
    localparam logic [2:0] TX_DATA = 3'd2;
    localparam logic [2:0] RX_DATA = 3'd3;
    localparam logic [2:0] BAUDIV  = 3'd4;

    // CTRL bit positions
    localparam int CTRL_TX_EN     = 0;
    localparam int CTRL_RX_EN     = 1;
    localparam int CTRL_PAR_EN    = 2;
    localparam int CTRL_PAR_ODD   = 3;
    localparam int CTRL_RX_IRQ_EN = 4;
    localparam int CTRL_TX_IRQ_EN = 5;
    localparam int CTRL_W         = 6;

    // STATUS bit positions
    localparam int STAT_TX_FULL    = 0;
    localparam int STAT_TX_BUSY    = 1;
    localparam int STAT_RX_VALID   = 2;
    localparam int STAT_RX_OVERRUN = 3;
    localparam int STAT_FRAME_ERR  = 4;
    localparam int STAT_TX_DROP    = 5;

    // TX holding register sequencer
    typedef enum logic {
        TX_IDLE  = 1'b0,
        TX_OFFER = 1'b1
    } tx_state_t;

endpackage

// File: rtl/uart_reg_ctrl_if.sv
// rtl/uart_reg_ctrl_if.sv - register-file strobe bus between apb_interface and uart_reg_ctrl
interface uart_reg_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              rf_wr_en;
    logic              rf_rd_en;
    logic [2:0]        rf_addr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rdata;

    // Bus side (apb_interface)
    modport master (
        output rf_wr_en,
        output rf_rd_en,
        output rf_addr,
        output rf_wdata,
        input  rf_rdata
    );

    // Register file side (uart_reg_ctrl)
    modport slave (
        input  rf_wr_en,
        input  rf_rd_en,
        input  rf_addr,
        input  rf_wdata,
        output rf_rdata
    );
endinterface

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - baud tick divider, one tick every div+1 enabled cycles
module uart_baud_gen #(
    parameter int BAUD_W = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              en,
    input  logic [BAUD_W-1:0] div,
    input  logic              clr,
    output logic              tick
);

    logic [BAUD_W-1:0] cnt_q;

    // Count enabled cycles; registered tick when the count reaches div, then reload to 0
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else if (clr || !en) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else if (cnt_q == div) begin
            cnt_q <= '0;
            tick  <= 1'b1;
        end else begin
            cnt_q <= cnt_q + 1'b1;
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_reg_ctrl.sv
// rtl/uart_reg_ctrl.sv - UART register file, TX hand-off sequencer, RX capture, baud tick and irq
module uart_reg_ctrl
    import uart_pkg::*;
#(
    parameter int                DATA_W         = 32,
    parameter int                BAUD_W         = 16,
    parameter logic [BAUD_W-1:0] DEFAULT_BAUDIV = BAUD_W'(26)
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    uart_reg_ctrl_if.slave        rf,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic                  tx_busy,
    input  logic [7:0]            rx_data,
    input  logic                  rx_strobe,
    input  logic                  rx_frame_err,
    output logic                  baud_tick,
    output logic                  ctrl_tx_en,
    output logic                  ctrl_rx_en,
    output logic                  ctrl_par_en,
    output logic                  ctrl_par_odd,
    output logic                  irq
);

    logic [CTRL_W-1:0] ctrl_q;
    logic [BAUD_W-1:0] baudiv_q;
    logic [7:0]        tx_hold_q;
    logic [7:0]        rx_byte_q;
    logic              rx_valid_q;
    logic              rx_overrun_q;
    logic              frame_err_q;
    logic              tx_drop_q;
    tx_state_t         state_q;
    tx_state_t         state_d;
    logic              tx_load;
    logic              tx_drop_set;
    logic              irq_q;
    logic [DATA_W-1:0] rdata_c;

    // Address decode of the write/read strobes
    logic wr_ctrl, wr_status, wr_txdata, wr_baudiv, rd_rxdata;
    assign wr_ctrl   = rf.rf_wr_en && (rf.rf_addr == CTRL);
    assign wr_status = rf.rf_wr_en && (rf.rf_addr == STATUS);
    assign wr_txdata = rf.rf_wr_en && (rf.rf_addr == TX_DATA);
    assign wr_baudiv = rf.rf_wr_en && (rf.rf_addr == BAUDIV);
    assign rd_rxdata = rf.rf_rd_en && (rf.rf_addr == RX_DATA);

    // Upper write-data bits have no home in any register
    logic unused_wdata;
    assign unused_wdata = ^rf.rf_wdata[DATA_W-1:BAUD_W];

    // Write-one-to-clear requests for the sticky STATUS bits
    logic clr_overrun, clr_frame_err, clr_tx_drop;
    assign clr_overrun   = wr_status && rf.rf_wdata[STAT_RX_OVERRUN];
    assign clr_frame_err = wr_status && rf.rf_wdata[STAT_FRAME_ERR];
    assign clr_tx_drop   = wr_status && rf.rf_wdata[STAT_TX_DROP];

    // TX handshake: offer only while a byte is held and the transmitter is enabled
    logic tx_full, tx_hs;
    assign tx_full  = (state_q == TX_OFFER);
    assign tx_valid = tx_full && ctrl_q[CTRL_TX_EN];
    assign tx_data  = tx_hold_q;
    assign tx_hs    = tx_valid && tx_ready;

    // RX capture: a clearing read in the same cycle frees the slot for the new byte
    logic rx_take, rx_capture, rx_overrun_set;
    assign rx_take        = ctrl_q[CTRL_RX_EN] && rx_strobe;
    assign rx_capture     = rx_take && (!rx_valid_q || rd_rxdata);
    assign rx_overrun_set = rx_take && rx_valid_q && !rd_rxdata;

    // CTRL and BAUDIV writable registers
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ctrl_q   <= '0;
            baudiv_q <= DEFAULT_BAUDIV;
        end else begin
            if (wr_ctrl)   ctrl_q   <= rf.rf_wdata[CTRL_W-1:0];
            if (wr_baudiv) baudiv_q <= rf.rf_wdata[BAUD_W-1:0];
        end
    end

    // TX FSM state register
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state_q <= TX_IDLE;
        else          state_q <= state_d;
    end

    // TX FSM next state: load, drop on a full slot, or release on handshake
    always_comb begin
        state_d     = state_q;
        tx_load     = 1'b0;
        tx_drop_set = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (wr_txdata) begin
                    tx_load = 1'b1;
                    state_d = TX_OFFER;
                end
            end
            TX_OFFER: begin
                if (wr_txdata && tx_hs) begin
                    tx_load = 1'b1;
                end else if (wr_txdata) begin
                    tx_drop_set = 1'b1;
                end else if (tx_hs) begin
                    state_d = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // TX holding byte, stable while the slot is full
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)     tx_hold_q <= '0;
        else if (tx_load) tx_hold_q <= rf.rf_wdata[7:0];
    end

    // RX byte and valid flag
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
        end else if (rx_capture) begin
            rx_byte_q  <= rx_data;
            rx_valid_q <= 1'b1;
        end else if (rd_rxdata) begin
            rx_valid_q <= 1'b0;
        end
    end

    // Sticky error flags; a new event wins over a same-cycle clear
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_overrun_q <= 1'b0;
            frame_err_q  <= 1'b0;
            tx_drop_q    <= 1'b0;
        end else begin
            if (rx_overrun_set)                  rx_overrun_q <= 1'b1;
            else if (clr_overrun)                rx_overrun_q <= 1'b0;
            if (rx_capture && rx_frame_err)      frame_err_q  <= 1'b1;
            else if (clr_frame_err)              frame_err_q  <= 1'b0;
            if (tx_drop_set)                     tx_drop_q    <= 1'b1;
            else if (clr_tx_drop)                tx_drop_q    <= 1'b0;
        end
    end

    // Registered interrupt from enabled sources and any sticky error
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) irq_q <= 1'b0;
        else          irq_q <= (ctrl_q[CTRL_RX_IRQ_EN] && rx_valid_q)
                             || (ctrl_q[CTRL_TX_IRQ_EN] && !tx_full)
                             || rx_overrun_q || frame_err_q || tx_drop_q;
    end
    assign irq = irq_q;

    // Combinational read mux, unused upper bits zero
    always_comb begin
        rdata_c = '0;
        case (rf.rf_addr)
            CTRL:    rdata_c[CTRL_W-1:0] = ctrl_q;
            STATUS:  rdata_c[5:0] = {tx_drop_q, frame_err_q, rx_overrun_q,
                                     rx_valid_q, tx_busy, tx_full};
            TX_DATA: rdata_c[7:0] = tx_hold_q;
            RX_DATA: rdata_c[7:0] = rx_byte_q;
            BAUDIV:  rdata_c[BAUD_W-1:0] = baudiv_q;
            default: rdata_c = '0;
        endcase
    end
    assign rf.rf_rdata = rdata_c;

    assign ctrl_tx_en   = ctrl_q[CTRL_TX_EN];
    assign ctrl_rx_en   = ctrl_q[CTRL_RX_EN];
    assign ctrl_par_en  = ctrl_q[CTRL_PAR_EN];
    assign ctrl_par_odd = ctrl_q[CTRL_PAR_ODD];

    uart_baud_gen #(
        .BAUD_W (BAUD_W)
    ) u_baud_gen (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .en      (ctrl_q[CTRL_TX_EN] || ctrl_q[CTRL_RX_EN]),
        .div     (baudiv_q),
        .clr     (wr_baudiv),
        .tick    (baud_tick)
    );

endmodule

// File: tb/tb_uart_reg_ctrl.sv
// tb/tb_uart_reg_ctrl.sv - scoreboard bench for uart_reg_ctrl with directed vectors
module tb_uart_reg_ctrl;

    localparam int P_READ = 0;
    localparam int P_TXVD = 1;
    localparam int P_TICK = 2;
    localparam int P_IRQ  = 3;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       name;
    } chk_t;

    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       tx_busy = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_strobe = 1'b0;
    logic       rx_frame_err = 1'b0;
    logic       baud_tick;
    logic       ctrl_tx_en, ctrl_rx_en, ctrl_par_en, ctrl_par_odd;
    logic       irq;
    logic       probe = 1'b0;

    chk_t       exp_q[$];
    logic [7:0] tx_q[$];
    int         vecs = 0;
    int         fails = 0;

    uart_reg_ctrl_if #(.DATA_W(32)) rf_if ();

    uart_reg_ctrl dut (
        .PCLK         (PCLK),
        .PRESETn      (PRESETn),
        .rf           (rf_if.slave),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_busy      (tx_busy),
        .rx_data      (rx_data),
        .rx_strobe    (rx_strobe),
        .rx_frame_err (rx_frame_err),
        .baud_tick    (baud_tick),
        .ctrl_tx_en   (ctrl_tx_en),
        .ctrl_rx_en   (ctrl_rx_en),
        .ctrl_par_en  (ctrl_par_en),
        .ctrl_par_odd (ctrl_par_odd),
        .irq          (irq)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Monitor: pop and compare on every read strobe, probe cycle and TX handshake
    chk_t        e;
    logic [31:0] act;
    logic [7:0]  exp_b;
    always @(negedge PCLK) begin
        if (rf_if.rf_rd_en || probe) begin
            vecs++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_sample: got sample with empty expectation queue, required none");
            end else begin
                e = exp_q.pop_front();
                case (e.sel)
                    P_READ:  act = rf_if.rf_rdata;
                    P_TXVD:  act = {23'd0, tx_valid, tx_data};
                    P_TICK:  act = {31'd0, baud_tick};
                    default: act = {31'd0, irq};
                endcase
                if (act !== e.exp) begin
                    fails++;
                    $display("FAIL %s: got 0x%0h, required 0x%0h", e.name, act, e.exp);
                end
            end
        end
        if (tx_valid && tx_ready) begin
            vecs++;
            if (tx_q.size() == 0) begin
                fails++;
                $display("FAIL tx_handshake: got byte 0x%0h, required no handshake", tx_data);
            end else begin
                exp_b = tx_q.pop_front();
                if (tx_data !== exp_b) begin
                    fails++;
                    $display("FAIL tx_handshake: got byte 0x%0h, required 0x%0h", tx_data, exp_b);
                end
            end
        end
    end

    task automatic tick_cycle();
        @(posedge PCLK);
        #1;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d);
        rf_if.rf_wr_en = 1'b1;
        rf_if.rf_addr  = a;
        rf_if.rf_wdata = d;
        tick_cycle();
        rf_if.rf_wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [2:0] a, input logic [31:0] x, input string n);
        exp_q.push_back('{sel: P_READ, exp: x, name: n});
        rf_if.rf_rd_en = 1'b1;
        rf_if.rf_addr  = a;
        tick_cycle();
        rf_if.rf_rd_en = 1'b0;
    endtask

    task automatic do_probe(input int s, input logic [31:0] x, input string n);
        exp_q.push_back('{sel: s, exp: x, name: n});
        probe = 1'b1;
        tick_cycle();
        probe = 1'b0;
    endtask

    task automatic rx_pulse(input logic [7:0] d, input logic fe);
        rx_data      = d;
        rx_frame_err = fe;
        rx_strobe    = 1'b1;
        tick_cycle();
        rx_strobe    = 1'b0;
        rx_frame_err = 1'b0;
    endtask

    initial begin
        logic [31:0] rst_vals [8];
        rst_vals = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd26, 32'd0, 32'd0, 32'd0};
        rf_if.rf_wr_en = 1'b0;
        rf_if.rf_rd_en = 1'b0;
        rf_if.rf_addr  = 3'd0;
        rf_if.rf_wdata = 32'd0;
        repeat (3) @(posedge PCLK);
        #1;
        PRESETn = 1'b1;
        tick_cycle();

        // 1. Reset values on all indices
        for (int i = 0; i < 8; i++) do_read(3'(i), rst_vals[i], $sformatf("reset_rd%0d", i));

        // 2. Single byte offered while the transmitter stalls
        do_write(3'd0, 32'h1);
        do_write(3'd2, 32'hA5);
        for (int i = 0; i < 3; i++) do_probe(P_TXVD, 32'h1A5, "tx_offer_hold");
        tx_ready = 1'b1;
        tx_q.push_back(8'hA5);
        do_probe(P_TXVD, 32'h1A5, "tx_offer_hs");
        tx_ready = 1'b0;
        do_read(3'd1, 32'h00, "status_after_hs");

        // 3. Drop on full slot, W1C, same-cycle accept, tx_en gating
        do_write(3'd2, 32'h11);
        do_write(3'd2, 32'h22);
        do_probe(P_TXVD, 32'h111, "tx_keep_first");
        do_read(3'd1, 32'h21, "status_drop");
        do_write(3'd1, 32'h20);
        do_read(3'd1, 32'h01, "status_drop_clr");
        tx_ready = 1'b1;
        tx_q.push_back(8'h11);
        do_probe(P_TXVD, 32'h111, "tx_drain_11");
        tx_ready = 1'b0;
        do_write(3'd2, 32'h44);
        tx_ready = 1'b1;
        tx_q.push_back(8'h44);
        do_write(3'd2, 32'h55);
        tx_ready = 1'b0;
        do_read(3'd1, 32'h01, "status_hs_write");
        do_read(3'd2, 32'h55, "txdata_readback");
        do_write(3'd0, 32'h0);
        do_probe(P_TXVD, 32'h055, "tx_gated_off");
        do_write(3'd0, 32'h1);
        do_probe(P_TXVD, 32'h155, "tx_reoffer");
        tx_ready = 1'b1;
        tx_q.push_back(8'h55);
        do_probe(P_TXVD, 32'h155, "tx_drain_55");
        tx_ready = 1'b0;
        do_write(3'd0, 32'h0);

        // 4. RX capture, overrun, frame error, read-and-capture
        do_write(3'd0, 32'h2);
        rx_pulse(8'h3C, 1'b0);
        rx_pulse(8'h7E, 1'b0);
        do_read(3'd3, 32'h3C, "rx_keep_old");
        do_read(3'd1, 32'h08, "status_overrun");
        do_write(3'd1, 32'h08);
        do_read(3'd1, 32'h00, "status_ovr_clr");
        rx_pulse(8'h99, 1'b1);
        do_read(3'd1, 32'h14, "status_frame_err");
        rx_data   = 8'hAB;
        rx_strobe = 1'b1;
        do_read(3'd3, 32'h99, "rx_read_with_strobe");
        rx_strobe = 1'b0;
        do_read(3'd1, 32'h14, "status_no_overrun");
        do_read(3'd3, 32'hAB, "rx_new_byte");
        do_write(3'd1, 32'h10);
        do_read(3'd1, 32'h00, "status_fe_clr");

        // 5. Baud generator
        do_write(3'd0, 32'h0);
        do_write(3'd4, 32'h3);
        do_read(3'd4, 32'h3, "baudiv_rd");
        do_write(3'd0, 32'h1);
        for (int i = 0; i < 12; i++)
            do_probe(P_TICK, (i == 4 || i == 8) ? 32'd1 : 32'd0, $sformatf("tick_div3_c%0d", i));
        do_write(3'd4, 32'h0);
        do_probe(P_TICK, 32'd0, "tick_div0_c0");
        for (int i = 1; i < 5; i++) do_probe(P_TICK, 32'd1, $sformatf("tick_div0_c%0d", i));
        do_write(3'd0, 32'h0);
        tick_cycle();
        for (int i = 0; i < 3; i++) do_probe(P_TICK, 32'd0, "tick_disabled");

        // 6. Interrupt latency
        do_write(3'd0, 32'h12);
        rx_pulse(8'h55, 1'b0);
        do_probe(P_IRQ, 32'd0, "irq_strobe_p1");
        do_probe(P_IRQ, 32'd1, "irq_strobe_p2");
        do_read(3'd3, 32'h55, "irq_rx_read");
        do_probe(P_IRQ, 32'd1, "irq_read_p1");
        do_probe(P_IRQ, 32'd0, "irq_read_p2");
        do_write(3'd0, 32'h20);
        do_probe(P_IRQ, 32'd0, "irq_txen_p1");
        do_probe(P_IRQ, 32'd1, "irq_tx_empty");

        // 7. Reset mid-transfer
        do_write(3'd0, 32'h1);
        do_write(3'd2, 32'h77);
        do_probe(P_TXVD, 32'h177, "tx_before_reset");
        PRESETn = 1'b0;
        do_probe(P_TXVD, 32'h000, "tx_in_reset");
        PRESETn = 1'b1;
        do_read(3'd1, 32'h00, "status_post_reset");
        do_read(3'd4, 32'd26, "baudiv_post_reset");
        do_read(3'd2, 32'h00, "txdata_post_reset");
        do_read(3'd0, 32'h00, "ctrl_post_reset");

        repeat (2) tick_cycle();
        vecs++;
        if (exp_q.size() != 0 || tx_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d/%0d pending, required 0/0", exp_q.size(), tx_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
